seq_restoring_divider: RTL

- Iterative unsigned restoring divider for the KGP-RICS datapath: the inverse-direction companion to the carry-lookahead adder chain.
- Each cycle it does one trial subtraction (remainder minus divisor) and one quotient bit decision.
- Sits beside the ALU and serves DIV/MOD-class instructions through a start/done handshake.
- Holds results stable until the next accepted start.

---
 rtl/seq_restoring_divider.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
//------------------------------------------------------------------------------
// seq_restoring_divider
//
// Iterative unsigned restoring divider. It serves DIV/MOD-class instructions
// beside the ALU. Each CALC cycle shifts {R,Q} left by one bit, does one trial
// subtraction of the divisor, and decides one quotient bit. Results go to
// dedicated output registers only when an operation completes, so the outputs
// never show partial values. They hold until the next completion.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (aborts any operation)
//   start        request; sampled only in IDLE or DONE
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse, high in the DONE cycle
//   quotient     result quotient ({WIDTH{1}} on divide-by-zero)
//   remainder    result remainder (dividend on divide-by-zero)
//   div_by_zero  set when the last completed operation had divisor == 0
//
// Timing: if a start is accepted on edge A, a normal divide runs for WIDTH
// CALC cycles and is in DONE right after edge A+WIDTH. A divide-by-zero skips
// CALC and is in DONE right after edge A.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_restoring_divider #(
   parameter int WIDTH = 32,   // operand width, 4..64
   parameter int CNT_W = 6     // iteration counter width, 2^CNT_W > WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dvsr_q,  dvsr_d;   // captured divisor
   logic [WIDTH-1:0] q_q,     q_d;      // working quotient / dividend shifter
   logic [WIDTH-1:0] r_q,     r_d;      // working partial remainder
   logic [CNT_W-1:0] cnt_q,   cnt_d;    // iterations still to run
   logic [WIDTH-1:0] quot_q,  quot_d;   // visible quotient
   logic [WIDTH-1:0] rem_q,   rem_d;    // visible remainder
   logic             dbz_q,   dbz_d;    // visible divide-by-zero flag

   // One restoring step.
   // The shifted remainder needs WIDTH+1 bits. R < divisor, so 2R+1 can
   // reach 2^WIDTH when the divisor has its top bit set.
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] r_it;
   logic [WIDTH-1:0] q_it;

   always_comb begin
      r_sh  = {r_q, q_q[WIDTH-1]};
      trial = r_sh - {1'b0, dvsr_q};
      // Non-negative trial: keep the difference and set the quotient bit.
      // Negative trial: restore the shifted remainder. Its top bit is known
      // to be 0 then, because r_sh < divisor < 2^WIDTH.
      q_it  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
      r_it  = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      dvsr_d  = dvsr_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         // DONE accepts a new start exactly like IDLE, which allows
         // back-to-back operations with no idle gap.
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == '0) begin
                  // No iteration needed. Publish the fixed result directly.
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_CALC;
                  dvsr_d  = divisor;
                  q_d     = dividend;
                  r_d     = '0;
                  cnt_d   = CNT_W'(WIDTH);
               end
            end
         end

         S_CALC: begin
            q_d   = q_it;
            r_d   = r_it;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // The last step's result goes straight to the visible registers.
               state_d = S_DONE;
               quot_d  = q_it;
               rem_d   = r_it;
               dbz_d   = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dvsr_q  <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvsr_q  <= dvsr_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
